// File: rtl/spi_byte_master_pkg.sv
// Shared constants for the SPI byte master: FSM encoding, transfer type
// flags and the default filler byte clocked out during read-only transfers.
package spi_master_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_SEL      = 3'd2;
  localparam logic [2:0] ST_SHIFT_LO = 3'd3;
  localparam logic [2:0] ST_SHIFT_HI = 3'd4;
  localparam logic [2:0] ST_HOLD     = 3'd5;
  localparam logic [2:0] ST_DESEL    = 3'd6;

  localparam logic XFER_WRITE = 1'b0;
  localparam logic XFER_READ  = 1'b1;

  localparam logic [7:0] DEFAULT_DUMMY_BYTE = 8'h00;

  // States in which the flash must see chip select asserted.
  function automatic logic is_selected(input logic [2:0] state);
    return (state == ST_SETUP) || (state == ST_SEL) || (state == ST_SHIFT_LO) ||
           (state == ST_SHIFT_HI) || (state == ST_HOLD);
  endfunction

endpackage

// File: rtl/spi_byte_master_if.sv
// Byte-stream side of the SPI master: request, write channel and read channel.
// The slave modport is the SPI master block; the master modport is its user.
interface spi_byte_master_if;
  logic       en_i;
  logic [7:0] wr_data_i;
  logic       wr_valid_i;
  logic       wr_ready_o;
  logic [7:0] rd_data_o;
  logic       rd_valid_o;
  logic       rd_ready_i;

  modport slave (
    input  en_i, wr_data_i, wr_valid_i, rd_ready_i,
    output wr_ready_o, rd_data_o, rd_valid_o
  );

  modport master (
    output en_i, wr_data_i, wr_valid_i, rd_ready_i,
    input  wr_ready_o, rd_data_o, rd_valid_o
  );
endinterface

// File: rtl/spi_byte_master_timer.sv
// Down-counter shared by all timed FSM states: reloaded on every state entry,
// flags the first and the last cycle of a MULT-cycle interval.
module spi_half_period_timer #(
  parameter int MULT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic expire_o,
  output logic first_o
);

  localparam int W = $clog2(MULT + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(MULT);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= LOAD_VAL;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expire_o = (count_q == W'(1));
  assign first_o  = (count_q == LOAD_VAL);

endmodule

// File: rtl/spi_byte_master.sv
// Mode-0, MSB-first SPI master moving one byte per request between a
// valid/ready byte stream and the configuration flash pins.
module spi_byte_master
  import spi_master_pkg::*;
#(
  parameter int         SCK_PERIOD_MULTIPLIER = 4,
  parameter logic [7:0] DUMMY_BYTE            = DEFAULT_DUMMY_BYTE
) (
  input  logic             clk_i,
  input  logic             rst_i,
  spi_byte_master_if.slave bus,
  output logic             sck_o,
  output logic             csn_o,
  output logic             mosi_o,
  input  logic             miso_i
);

  logic [2:0] state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_q, bit_d;
  logic       xfer_q, xfer_d;
  logic       miso_q, miso_d;
  logic       rd_valid_q, rd_valid_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       load, expire, first;

  spi_half_period_timer #(.MULT(SCK_PERIOD_MULTIPLIER)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (load),
    .expire_o (expire),
    .first_o  (first)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_d      = bit_q;
    xfer_d     = xfer_q;
    miso_d     = miso_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;

    if (rd_valid_q && bus.rd_ready_i) rd_valid_d = 1'b0;

    case (state_q)
      ST_IDLE:     if (bus.en_i) state_d = ST_SETUP;
      ST_SETUP:    if (expire) state_d = ST_SEL;
      ST_SEL: begin
        if (!bus.en_i) begin
          state_d = ST_HOLD;
        end else if (bus.wr_valid_i) begin
          shreg_d = bus.wr_data_i;
          xfer_d  = XFER_WRITE;
          bit_d   = 3'd0;
          state_d = ST_SHIFT_LO;
        end else if (bus.rd_ready_i && !rd_valid_q) begin
          // Single-entry read buffer: only fetch when the previous byte is gone.
          shreg_d = DUMMY_BYTE;
          xfer_d  = XFER_READ;
          bit_d   = 3'd0;
          state_d = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: if (expire) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: begin
        if (first) miso_d = miso_i;
        if (expire) begin
          shreg_d = {shreg_q[6:0], miso_d};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            if (xfer_q == XFER_READ) begin
              rd_data_d  = {shreg_q[6:0], miso_d};
              rd_valid_d = 1'b1;
            end
            // A dropped request lets the byte finish, then goes straight to hold.
            state_d = bus.en_i ? ST_SEL : ST_HOLD;
          end else begin
            state_d = ST_SHIFT_LO;
          end
        end
      end
      ST_HOLD:     if (expire) state_d = ST_DESEL;
      ST_DESEL:    if (expire) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign load = (state_d != state_q);

  // Pin outputs are computed from the next state so they are glitch-free registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      shreg_q    <= 8'h00;
      bit_q      <= 3'd0;
      xfer_q     <= XFER_WRITE;
      miso_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      sck_o      <= 1'b0;
      csn_o      <= 1'b1;
      mosi_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_q      <= bit_d;
      xfer_q     <= xfer_d;
      miso_q     <= miso_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      sck_o      <= (state_d == ST_SHIFT_HI);
      csn_o      <= !is_selected(state_d);
      mosi_o     <= ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) ? shreg_d[7] : 1'b0;
    end
  end

  assign bus.wr_ready_o = (state_q == ST_SEL) && bus.en_i;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_data_o  = rd_data_q;

endmodule
